// File: rtl/seg_display_scan.sv
// Four-digit seven-segment scanner: snapshots the digit patterns once per frame,
// multiplexes them onto shared seg/an pins with a blank lead-in per slot and per-digit blink.
module seg_display_scan #(
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int BLINK_FRAMES = 125
) (
  input  logic       Clk100M,
  input  logic       reset,
  input  logic [7:0] seg0,
  input  logic [7:0] seg1,
  input  logic [7:0] seg2,
  input  logic [7:0] seg3,
  input  logic [3:0] blink_mask,
  output logic [7:0] seg,
  output logic [3:0] an,
  output logic       frame_start
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = $clog2(BLINK_FRAMES) + 1;

  localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW:0]   BLANK_LIM = (CW + 1)'(BLANK_CYCLES);
  localparam logic [FW-1:0] FRAME_END = FW'(BLINK_FRAMES - 1);

  typedef enum logic {
    ST_START,
    ST_SCAN
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [1:0]      d;
  logic [7:0]      snap [4];
  logic [3:0]      mask_q;
  logic [FW-1:0]   fcnt;
  logic            blink_phase;
  logic            blink_q;

  logic [CW-1:0]   cnt_nx;
  logic [1:0]      d_nx;
  logic            new_frame;
  logic [7:0]      snap_nx [4];
  logic [3:0]      mask_nx;
  logic [FW-1:0]   fcnt_nx;
  logic            phase_nx;
  logic            show_phase;
  logic            drive_nx;

  // The registers describe the cycle that follows the edge, so outputs are
  // computed from next-state values and switch anode and pattern together.
  always_comb begin
    cnt_nx    = '0;
    d_nx      = '0;
    new_frame = 1'b1;
    if (state == ST_SCAN) begin
      if (cnt == CNT_LAST) begin
        cnt_nx    = '0;
        d_nx      = d + 2'd1;
        new_frame = (d == 2'd3);
      end else begin
        cnt_nx    = cnt + 1'b1;
        d_nx      = d;
        new_frame = 1'b0;
      end
    end

    snap_nx    = snap;
    mask_nx    = mask_q;
    fcnt_nx    = fcnt;
    phase_nx   = blink_phase;
    show_phase = blink_q;
    if (new_frame) begin
      snap_nx[0] = seg0;
      snap_nx[1] = seg1;
      snap_nx[2] = seg2;
      snap_nx[3] = seg3;
      mask_nx    = blink_mask;
      show_phase = blink_phase;
      if (fcnt == FRAME_END) begin
        fcnt_nx  = '0;
        phase_nx = ~blink_phase;
      end else begin
        fcnt_nx  = fcnt + 1'b1;
      end
    end

    drive_nx = ({1'b0, cnt_nx} >= BLANK_LIM) && !(mask_nx[d_nx] && show_phase);
  end

  always_ff @(posedge Clk100M) begin
    if (reset) begin
      state       <= ST_START;
      cnt         <= '0;
      d           <= '0;
      for (int i = 0; i < 4; i++) snap[i] <= 8'hFF;
      mask_q      <= '0;
      fcnt        <= '0;
      blink_phase <= 1'b0;
      blink_q     <= 1'b0;
      seg         <= 8'hFF;
      an          <= 4'hF;
      frame_start <= 1'b0;
    end else begin
      state       <= ST_SCAN;
      cnt         <= cnt_nx;
      d           <= d_nx;
      snap        <= snap_nx;
      mask_q      <= mask_nx;
      fcnt        <= fcnt_nx;
      blink_phase <= phase_nx;
      blink_q     <= show_phase;
      frame_start <= new_frame;
      if (drive_nx) begin
        an  <= ~(4'b0001 << d_nx);
        seg <= snap_nx[d_nx];
      end else begin
        an  <= 4'hF;
        seg <= 8'hFF;
      end
    end
  end

endmodule

// File: tb/tb_seg_display_scan.sv
// Scoreboard bench for seg_display_scan: a cycle-position model pushes expected
// outputs each edge; per-scenario tasks pop and compare them.
module tb_seg_display_scan;

  localparam int SD = 8;
  localparam int BL = 2;
  localparam int BF = 2;

  logic       clk;
  logic       reset;
  logic [7:0] seg0, seg1, seg2, seg3;
  logic [3:0] blink_mask;
  logic [7:0] seg, seg_b;
  logic [3:0] an, an_b;
  logic       fs, fs_b;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         t;
    logic       fs;
    logic [3:0] an;
    logic [7:0] seg;
    logic [3:0] an_nb;
    logic [7:0] seg_nb;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   mt = -1;
  logic [7:0] msnap [4];
  logic [3:0] mmask;

  seg_display_scan #(.SCAN_DIV(SD), .BLANK_CYCLES(BL), .BLINK_FRAMES(BF)) dut (
    .Clk100M(clk), .reset(reset),
    .seg0(seg0), .seg1(seg1), .seg2(seg2), .seg3(seg3),
    .blink_mask(blink_mask),
    .seg(seg), .an(an), .frame_start(fs)
  );

  seg_display_scan #(.SCAN_DIV(SD), .BLANK_CYCLES(0), .BLINK_FRAMES(BF)) dut_nb (
    .Clk100M(clk), .reset(reset),
    .seg0(seg0), .seg1(seg1), .seg2(seg2), .seg3(seg3),
    .blink_mask(blink_mask),
    .seg(seg_b), .an(an_b), .frame_start(fs_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {an, seg} for the cycle t positions after the first post-reset edge.
  function automatic logic [11:0] model_out(int t, int blank);
    int slot, c, frame;
    logic off;
    logic [3:0] one;
    one   = 4'b0001;
    slot  = (t / SD) % 4;
    c     = t % SD;
    frame = t / (4 * SD);
    off   = (c < blank) || (mmask[slot] && (((frame / BF) % 2) == 1));
    if (off) return {4'hF, 8'hFF};
    return {~(one << slot), msnap[slot]};
  endfunction

  task automatic tick();
    exp_t x;
    @(posedge clk);
    if (reset) begin
      mt = -1;
      x.t = -1; x.fs = 1'b0;
      x.an = 4'hF; x.seg = 8'hFF; x.an_nb = 4'hF; x.seg_nb = 8'hFF;
    end else begin
      mt = (mt < 0) ? 0 : mt + 1;
      if (mt % (4 * SD) == 0) begin
        msnap[0] = seg0; msnap[1] = seg1; msnap[2] = seg2; msnap[3] = seg3;
        mmask = blink_mask;
      end
      x.t  = mt;
      x.fs = (mt % (4 * SD) == 0);
      {x.an, x.seg}       = model_out(mt, BL);
      {x.an_nb, x.seg_nb} = model_out(mt, 0);
    end
    q.push_back(x);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [7:0] s0, s1, s2, s3, input logic [3:0] m);
    seg0 = s0; seg1 = s1; seg2 = s2; seg3 = s3; blink_mask = m;
  endtask

  task automatic restart();
    reset = 1'b1;
    tick();
    void'(q.pop_front());
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      e = q.pop_front();
      total++;
      if (fs !== 1'b0 || an !== 4'hF || seg !== 8'hFF) begin
        bad++;
        $display("[TB] FAIL reset fs/an/seg got=%b/%h/%h exp=0/f/ff", fs, an, seg);
      end
    end
  endtask

  task automatic test_basic_scan();
    applyStimulus(8'hC0, 8'hF9, 8'hA4, 8'hB0, 4'b0000);
    restart();
    for (int i = 0; i < 64; i++) begin
      tick();
      e = q.pop_front();
      total++;
      if (fs !== e.fs || an !== e.an || seg !== e.seg) begin
        bad++;
        $display("[TB] FAIL basic t=%0d got fs=%b an=%b seg=%h exp fs=%b an=%b seg=%h",
                 e.t, fs, an, seg, e.fs, e.an, e.seg);
      end
      if (e.t == 2 || e.t == 34) begin
        total++;
        if (an !== 4'b1110 || seg !== 8'hC0) begin
          bad++;
          $display("[TB] FAIL basic_digit0 t=%0d got an=%b seg=%h exp an=1110 seg=c0", e.t, an, seg);
        end
      end
      if (e.t == 31) begin
        total++;
        if (an !== 4'b0111 || seg !== 8'hB0) begin
          bad++;
          $display("[TB] FAIL basic_digit3 got an=%b seg=%h exp an=0111 seg=b0", an, seg);
        end
      end
      if (e.t == 0 || e.t == 32) begin
        total++;
        if (fs !== 1'b1) begin
          bad++;
          $display("[TB] FAIL basic_frame_start t=%0d got=%b exp=1", e.t, fs);
        end
      end
    end
  endtask

  task automatic test_snapshot();
    applyStimulus(8'hC0, 8'hF9, 8'hA4, 8'hB0, 4'b0000);
    restart();
    for (int i = 0; i < 64; i++) begin
      tick();
      e = q.pop_front();
      if (e.t == 10) seg2 = 8'h99;
      total++;
      if (fs !== e.fs || an !== e.an || seg !== e.seg) begin
        bad++;
        $display("[TB] FAIL snapshot t=%0d got fs=%b an=%b seg=%h exp fs=%b an=%b seg=%h",
                 e.t, fs, an, seg, e.fs, e.an, e.seg);
      end
      if (e.t == 20 || e.t == 52) begin
        total++;
        if (seg !== ((e.t == 20) ? 8'hA4 : 8'h99)) begin
          bad++;
          $display("[TB] FAIL snapshot_digit2 t=%0d got=%h exp=%h", e.t, seg,
                   (e.t == 20) ? 8'hA4 : 8'h99);
        end
      end
    end
  endtask

  task automatic test_blink();
    applyStimulus(8'hC0, 8'hF9, 8'hA4, 8'hB0, 4'b0100);
    restart();
    for (int i = 0; i < 6 * 4 * SD; i++) begin
      tick();
      e = q.pop_front();
      total++;
      if (fs !== e.fs || an !== e.an || seg !== e.seg) begin
        bad++;
        $display("[TB] FAIL blink t=%0d got fs=%b an=%b seg=%h exp fs=%b an=%b seg=%h",
                 e.t, fs, an, seg, e.fs, e.an, e.seg);
      end
      if (e.t == 52 || e.t == 84 || e.t == 116 || e.t == 148) begin
        total++;
        if ((e.t == 84 || e.t == 116) ? (an !== 4'hF || seg !== 8'hFF)
                                      : (an !== 4'b1011 || seg !== 8'hA4)) begin
          bad++;
          $display("[TB] FAIL blink_digit2 t=%0d got an=%b seg=%h", e.t, an, seg);
        end
      end
      if (e.t == 90) begin
        total++;
        if (an !== 4'b0111 || seg !== 8'hB0) begin
          bad++;
          $display("[TB] FAIL blink_other got an=%b seg=%h exp an=0111 seg=b0", an, seg);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    applyStimulus(8'h11, 8'h22, 8'h33, 8'h44, 4'b0000);
    restart();
    for (int i = 0; i < 13; i++) begin
      tick();
      e = q.pop_front();
    end
    reset = 1'b1;
    tick();
    e = q.pop_front();
    total++;
    if (fs !== 1'b0 || an !== 4'hF || seg !== 8'hFF) begin
      bad++;
      $display("[TB] FAIL reset_mid got fs=%b an=%h seg=%h exp 0/f/ff", fs, an, seg);
    end
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      e = q.pop_front();
      total++;
      if (fs !== e.fs || an !== e.an || seg !== e.seg) begin
        bad++;
        $display("[TB] FAIL reset_restart t=%0d got fs=%b an=%b seg=%h exp fs=%b an=%b seg=%h",
                 e.t, fs, an, seg, e.fs, e.an, e.seg);
      end
      if (e.t == 2) begin
        total++;
        if (an !== 4'b1110 || seg !== 8'h11) begin
          bad++;
          $display("[TB] FAIL reset_restart_digit0 got an=%b seg=%h exp an=1110 seg=11", an, seg);
        end
      end
    end
  endtask

  task automatic test_no_blank();
    applyStimulus(8'hC0, 8'hF9, 8'hA4, 8'hB0, 4'b0000);
    restart();
    for (int i = 0; i < 40; i++) begin
      tick();
      e = q.pop_front();
      total++;
      if (fs_b !== e.fs || an_b !== e.an_nb || seg_b !== e.seg_nb) begin
        bad++;
        $display("[TB] FAIL no_blank t=%0d got fs=%b an=%b seg=%h exp fs=%b an=%b seg=%h",
                 e.t, fs_b, an_b, seg_b, e.fs, e.an_nb, e.seg_nb);
      end
      if (e.t == 0 || e.t == 7 || e.t == 8) begin
        total++;
        if (an_b !== ((e.t == 8) ? 4'b1101 : 4'b1110)) begin
          bad++;
          $display("[TB] FAIL no_blank_anode t=%0d got=%b", e.t, an_b);
        end
      end
    end
  endtask

  task automatic test_soak();
    int zeros;
    restart();
    for (int i = 0; i < 2000; i++) begin
      applyStimulus(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 4'($urandom));
      reset = ($urandom_range(0, 99) == 0);
      tick();
      e = q.pop_front();
      total++;
      if (fs !== e.fs || an !== e.an || seg !== e.seg || an_b !== e.an_nb || seg_b !== e.seg_nb) begin
        bad++;
        $display("[TB] FAIL soak t=%0d got an=%b seg=%h an0=%b seg0=%h exp an=%b seg=%h an0=%b seg0=%h",
                 e.t, an, seg, an_b, seg_b, e.an, e.seg, e.an_nb, e.seg_nb);
      end
      zeros = 0;
      for (int b = 0; b < 4; b++) if (an[b] == 1'b0) zeros++;
      total++;
      if (zeros > 1) begin
        bad++;
        $display("[TB] FAIL soak_exclusive t=%0d an=%b", e.t, an);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(8'hFF, 8'hFF, 8'hFF, 8'hFF, 4'b0000);
    for (int i = 0; i < 4; i++) msnap[i] = 8'hFF;
    mmask = 4'b0000;
    @(negedge clk);
    test_reset();
    test_basic_scan();
    test_snapshot();
    test_blink();
    test_reset_mid();
    test_no_blank();
    test_soak();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_display_scan.md
# seg_display_scan

Four-digit seven-segment display scanner. It consumes the four per-digit segment patterns produced by the game-play logic and time-multiplexes them onto the board's shared `seg`/`an` pins. It sits between the game-play module and the top-level `seg`/`an` outputs. Each digit slot is split into an anti-ghosting blank interval and a drive interval. The four patterns are snapshotted at every frame start, and per-digit blinking is supported.

## Interface
- `SCAN_DIV`, 100000: cycles per digit slot; must be ≥ 2. The default gives a 1 kHz slot rate and a 250 Hz frame rate at 100 MHz.
- `BLANK_CYCLES`, 1000: blank cycles at the start of each slot; 0 ≤ `BLANK_CYCLES` < `SCAN_DIV`.
- `BLINK_FRAMES`, 125: frames per blink half-period; must be ≥ 1.
- `Clk100M` in 1: the single clock; all logic is on its rising edge.
- `reset` in 1: synchronous, active-high.
- `seg0`..`seg3` in 8 each: active-low segment patterns, bit 7 = dp. `seg0` is the rightmost digit (`an[0]`).
- `blink_mask` in 4: bit d=1 makes digit d blink.
- `seg` out 8: active-low segments.
- `an` out 4: active-low anodes.
- `frame_start` out 1: one-cycle pulse when a new snapshot is taken.

## Operation
- **State.**
  - Slot counter `cnt`: width clog2(`SCAN_DIV`).
  - Digit index `d`: 2 bits.
  - Snapshot registers `snap[0..3]` (8 bits each) and `mask_q` (4 bits).
  - Frame counter `fcnt`: width clog2(`BLINK_FRAMES`)+1.
  - `blink_phase`: 1 bit.
- **Reset values.**
  - `cnt`=0, `d`=0, `fcnt`=0, `blink_phase`=0.
  - `snap[*]`=8'hFF, `mask_q`=0.
  - Outputs: `seg`=8'hFF, `an`=4'hF, `frame_start`=0.
- **Slot phases.** Each slot has two phases:
  - BLANK: `cnt` < `BLANK_CYCLES`. Outputs are `an`=4'hF, `seg`=8'hFF.
  - DRIVE: `cnt` ≥ `BLANK_CYCLES`. Outputs are `an`=~(4'b0001<<`d`) and `seg`=`snap[d]`.
  - Blink override in DRIVE: if `mask_q[d]` && `blink_phase`, the digit is suppressed and `an`=4'hF, `seg`=8'hFF.
- **Counting.**
  - `cnt` increments every cycle. At `SCAN_DIV`-1 it wraps to 0 and `d` increments, wrapping from 3 to 0.
- **Frame start.** A frame starts at the first non-reset edge and at every wrap of `d` from 3 to 0. At each frame start:
  - `snap[i]`←`seg_i` and `mask_q`←`blink_mask`.
  - `frame_start`=1 for exactly one cycle.
  - `fcnt` increments. When it reaches `BLINK_FRAMES` it clears to 0 and `blink_phase` toggles.
- **Input changes.** Input changes mid-frame are ignored until the next frame start, so the displayed frame is always coherent.
- **Anode exclusivity.** At most one `an` bit is ever low. `an` and `seg` change on the same edge; no cycle drives a new digit's anode with the previous digit's pattern.
- **Reset mid-operation.** All state returns to reset values on the next edge. The sequence restarts from frame start on the first edge with `reset`=0.

## Timing
- All outputs are registered.
- Let E0 be the first rising edge with `reset`=0. After E0:
  - `frame_start`=1 for one cycle.
  - Snapshot loaded.
  - Outputs blank for `BLANK_CYCLES` cycles.
- **Per slot, relative to slot start S:**
  - Blank for `BLANK_CYCLES` cycles.
  - Digit driven from S+`BLANK_CYCLES` through S+`SCAN_DIV`-1.
  - Slot k starts `k*SCAN_DIV` cycles after E0.
- Frame period = 4·`SCAN_DIV` cycles. `frame_start` pulses after E0 + n·4·`SCAN_DIV`.
- Blink: each suppressed or visible phase lasts `BLINK_FRAMES` frames. Frames 0..`BLINK_FRAMES`-1 after reset are visible.
- With `BLANK_CYCLES`=0, the digit is driven for the full slot, starting right after E0.
- Latency from a `seg_i` input change to display: up to one frame plus the slot offset.

## Test plan
Use `SCAN_DIV`=8, `BLANK_CYCLES`=2, `BLINK_FRAMES`=2 unless noted.

1. **Basic scan.** Reset, then `seg0`..`seg3`=C0,F9,A4,B0 and `blink_mask`=0.
   - `frame_start` pulses after E0.
   - Each digit gets 2 blank cycles then 6 drive cycles: `an`=1110/`seg`=C0, then 1101/F9, then 1011/A4, then 0111/B0.
   - The next `frame_start` occurs 32 cycles after E0, and the pattern repeats.
2. **Snapshot.** Set `seg2`=99 at cycle 10 of frame 0.
   - Digit 2 still shows A4 in frame 0.
   - Digit 2 shows 99 from frame 1 onward.
3. **Blink.** `blink_mask`=0100.
   - Digit 2 shows A4 in frames 0–1.
   - Frames 2–3 have `an`=F and `seg`=FF throughout slot 2.
   - Frames 4–5 are visible again; the other digits are unaffected.
4. **Reset mid-slot.** Assert `reset` for 1 cycle at cycle 13.
   - On the next edge `an`=F, `seg`=FF, `frame_start`=0.
   - After release, `frame_start` pulses and the sequence restarts at digit 0.
5. **No blanking.** Build with `BLANK_CYCLES`=0.
   - `an`=1110 from the first cycle after E0 for 8 cycles, then 1101, with no blank cycles.
6. **Random soak.** 2000 cycles with random `seg_i`, `blink_mask` and occasional `reset`.
   - Checker confirms `an` never has more than one zero.
   - `an`=F whenever `cnt`<2.
   - `seg` equals the frame's snapshot of the active digit whenever an anode is low.
